dt_res_packer: RTL and testbench
================================

Name: dt_res_packer

Overview:
- Reads the 128x128 8-bit distance map from the res RAM after the distance-transform pass.
- Thresholds each pixel and packs the results back into the 1024 x 16-bit binary image format of the sti memory, writing through a write port.
- It is the write-back counterpart of the sti-reader/res-writer path. It re-binarises a processed map, e.g. for erosion by distance, for the next pass or for host readback.
- Also reports the number of pixels that passed the threshold.

Parameters:
N_WORDS, 1024, number of 16-bit sti words; the res map holds N_WORDS*16 pixels.
WORD_BITS, 16, pixels packed per sti word (fixed at 16; other values unsupported).

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a full packing pass; ignored while busy=1
threshold  input  8  pixel passes if res_di >= threshold (unsigned); sampled on the accepted start
res_rd  output  1  res RAM read enable
res_addr  output  14  res RAM read address
res_di  input  8  res RAM read data, valid in the same cycle as res_rd/res_addr (combinational read)
sti_wr  output  1  sti memory write enable, one-cycle pulse per word
sti_addr  output  10  sti word address
sti_do  output  16  packed word, valid while sti_wr=1
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last word is written
obj_count  output  15  number of passing pixels in the last or current pass; holds after done

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - res_rd, sti_wr, busy and done go to 0.
  - res_addr, sti_addr, sti_do and obj_count go to 0.
  - The latched threshold goes to 0.
  - A pass interrupted by reset is abandoned; no further writes occur and no partial word is written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs are 0, except obj_count, which holds.
  - On start=1: latch threshold, clear the pixel counter, word counter, shift/pack register and obj_count, then go to READ.
- READ:
  - Exactly 16 consecutive cycles per word, with res_rd=1.
  - res_addr = word_idx*16 + bit_idx, where bit_idx runs 0..15.
  - At each rising edge, bit[bit_idx] of the pack register = (res_di >= thr_latched), and obj_count increments when that bit is 1.
  - After bit_idx 15, go to WRITE.
- WRITE:
  - One cycle with sti_wr=1, sti_addr = word_idx, and sti_do = the completed pack register including the bit captured at the last READ edge.
  - res_rd=0 in this cycle.
  - If word_idx = N_WORDS-1, go to DONE. Otherwise increment word_idx, clear the pack register and return to READ.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Bit mapping: the pixel at res address 16*w + k maps to bit k of sti word w (bit 0 = leftmost pixel of the group). This matches the order in which the forward distance-transform pass consumes sti words.
- Timing:
  - Per word: 17 cycles.
  - Full pass: 1024*17 = 17408 cycles from the first READ cycle to the last WRITE cycle.
  - done asserts in the following cycle.
- Outputs when not active: res_addr is 0 whenever res_rd=0; sti_addr and sti_do are 0 whenever sti_wr=0.
- Threshold arithmetic:
  - Comparison is unsigned 8-bit.
  - threshold=0 makes every pixel pass (obj_count = 16384, fits 15 bits).
  - threshold=255 passes only pixels equal to 255.
- Simultaneous events:
  - start during READ, WRITE or DONE is ignored.
  - start in the same cycle that DONE returns to IDLE is ignored; start must arrive while in IDLE.
  - Changes to the threshold input mid-pass have no effect.
- Counter widths and wrap-around: address counters never wrap mid-pass. The word index stops at N_WORDS-1, and the res address stops at 16383.

Test Plan:
1. All res=0, threshold=1, start → 1024 writes, every sti_do=16'h0000, sti_addr 0..1023 in order, obj_count=0, done exactly 17409 cycles after the start edge.
2. res[a] = a[7:0], threshold=128 → every word = 16'h0000 or 16'hFFFF, alternating per 128 pixels (words 0-7 = 0x0000, words 8-15 = 0xFFFF, ...); obj_count=8192.
3. Only res[16*5+3]=9, rest 0, threshold=9 → word 5 = 16'h0008, all other words 0; obj_count=1; res_rd pattern of 16 high then 1 low per word.
4. threshold=0 with arbitrary data → all words 16'hFFFF, obj_count=16384. start pulses and threshold changes mid-pass are ignored; the final result is unchanged.
5. Assert reset during READ of word 300 → all outputs 0 immediately and no sti_wr afterwards. A new start then produces a clean full pass from word 0 with correct obj_count.
6. Back-to-back passes: a start in the cycle after done is accepted. The second pass with a different threshold overwrites obj_count, which is cleared at start.

Source files
------------

// File: rtl/dt_res_packer.sv
// dt_res_packer: thresholds the res distance map and packs the
// result back into 16-bit sti words, counting passing pixels.
module dt_res_packer #(
  parameter int N_WORDS   = 1024,
  parameter int WORD_BITS = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [7:0]                                 threshold,
  output logic                                       res_rd,
  output logic [$clog2(N_WORDS)+$clog2(WORD_BITS)-1:0] res_addr,
  input  logic [7:0]                                 res_di,
  output logic                                       sti_wr,
  output logic [$clog2(N_WORDS)-1:0]                 sti_addr,
  output logic [WORD_BITS-1:0]                       sti_do,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(N_WORDS)+$clog2(WORD_BITS):0] obj_count
);

  localparam int WW = $clog2(N_WORDS);
  localparam int BW = $clog2(WORD_BITS);
  localparam int CW = WW + BW + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           thr_q, thr_d;
  logic [WW-1:0]        word_q, word_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] pack_q, pack_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 hit;

  assign hit = (res_di >= thr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      thr_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      pack_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    word_d  = word_q;
    bit_d   = bit_q;
    pack_d  = pack_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          thr_d   = threshold;
          word_d  = '0;
          bit_d   = '0;
          pack_d  = '0;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        pack_d[bit_q] = hit;
        if (hit) cnt_d = cnt_q + CW'(1);
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(WORD_BITS - 1)) state_d = WRITE;
      end
      WRITE: begin
        if (word_q == WW'(N_WORDS - 1)) begin
          state_d = DONE;
        end else begin
          word_d  = word_q + WW'(1);
          pack_d  = '0;
          state_d = READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data buses are forced to zero outside their strobes.
  always_comb begin
    res_rd    = (state_q == READ);
    sti_wr    = (state_q == WRITE);
    busy      = (state_q == READ) || (state_q == WRITE);
    done      = (state_q == DONE);
    res_addr  = res_rd ? {word_q, bit_q} : '0;
    sti_addr  = sti_wr ? word_q : '0;
    sti_do    = sti_wr ? pack_q : '0;
    obj_count = cnt_q;
  end

endmodule

// File: tb/tb_dt_res_packer.sv
// tb_dt_res_packer: directed scenarios for the res-to-sti packer.
// Each task drives one scenario and checks its own results.
module tb_dt_res_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  threshold;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic        busy;
  logic        done;
  logic [14:0] obj_count;

  logic [7:0]  mem [0:16383];
  logic [15:0] got [0:1023];
  int          wr_cnt, order_bad, rd_bad, idle_bad;
  int          first_cnt;
  int          errors = 0;
  int          checks = 0;

  dt_res_packer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .threshold (threshold),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .sti_wr    (sti_wr),
    .sti_addr  (sti_addr),
    .sti_do    (sti_do),
    .busy      (busy),
    .done      (done),
    .obj_count (obj_count)
  );

  assign res_di = mem[res_addr];

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] model_word(int w, logic [7:0] thr);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (mem[16 * w + k] >= thr);
    return r;
  endfunction

  // Runs one pass, recording writes and strobe statistics; cyc is the
  // number of cycles from the start cycle to done, or -1 on timeout.
  task automatic run_pass(input logic [7:0] thr, input bit disturb,
                          output int cyc);
    int run;
    int nxt;
    wr_cnt = 0; order_bad = 0; rd_bad = 0; idle_bad = 0;
    run = 0; nxt = 0; cyc = -1;
    for (int i = 0; i < 1024; i++) got[i] = 'x;
    @(negedge clk);
    start = 1'b1;
    threshold = thr;
    for (int n = 1; n <= 20000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        first_cnt = int'(obj_count);
      end
      if (disturb && n == 100) begin
        start = 1'b1;
        threshold = ~thr;
      end
      if (disturb && n == 101) start = 1'b0;
      if (disturb && n == 5000) threshold = 8'h55;
      if (res_rd) begin
        run++;
      end else begin
        if (run != 0 && run != 16) rd_bad++;
        run = 0;
        if (res_addr != 0) idle_bad++;
      end
      if (sti_wr) begin
        got[sti_addr] = sti_do;
        if (int'(sti_addr) != nxt) order_bad++;
        nxt++;
        wr_cnt++;
      end else if (sti_addr != 0 || sti_do != 0) begin
        idle_bad++;
      end
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    threshold = 8'h00;
    #12;
    checks++;
    if ({res_rd, sti_wr, busy, done} !== 4'b0) begin
      $display("FAIL reset_strobes: got %b expected 0000",
               {res_rd, sti_wr, busy, done});
      errors++;
    end
    checks++;
    if ({res_addr, sti_addr, sti_do} !== 40'd0) begin
      $display("FAIL reset_buses: got %h expected 0",
               {res_addr, sti_addr, sti_do});
      errors++;
    end
    checks++;
    if (obj_count !== 15'd0) begin
      $display("FAIL reset_count: got %0d expected 0", obj_count);
      errors++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ramp;
    int cyc;
    int bad;
    for (int a = 0; a < 16384; a++) mem[a] = 8'(a);
    run_pass(8'd128, 1'b0, cyc);
    checks++;
    if (cyc !== 17409) begin
      $display("FAIL ramp_cycles: got %0d expected 17409", cyc);
      errors++;
    end
    checks++;
    if (got[0] !== 16'h0000 || got[7] !== 16'h0000) begin
      $display("FAIL ramp_low: got %h %h expected 0000", got[0], got[7]);
      errors++;
    end
    checks++;
    if (got[8] !== 16'hFFFF || got[15] !== 16'hFFFF) begin
      $display("FAIL ramp_high: got %h %h expected ffff", got[8], got[15]);
      errors++;
    end
    checks++;
    if (got[16] !== 16'h0000 || got[1023] !== 16'hFFFF) begin
      $display("FAIL ramp_wrap: got %h %h expected 0000 ffff",
               got[16], got[1023]);
      errors++;
    end
    bad = 0;
    for (int w = 0; w < 1024; w++)
      if (got[w] !== model_word(w, 8'd128)) bad++;
    checks++;
    if (bad != 0) begin
      $display("FAIL ramp_words: got %0d bad words expected 0", bad);
      errors++;
    end
    checks++;
    if (obj_count !== 15'd8192) begin
      $display("FAIL ramp_count: got %0d expected 8192", obj_count);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_pass(8'd255, 1'b0, cyc);
    checks++;
    if (first_cnt != 0) begin
      $display("FAIL b2b_cleared: got %0d expected 0", first_cnt);
      errors++;
    end
    checks++;
    if (cyc !== 17409) begin
      $display("FAIL b2b_cycles: got %0d expected 17409", cyc);
      errors++;
    end
    checks++;
    if (got[15] !== 16'h8000 || got[14] !== 16'h0000) begin
      $display("FAIL b2b_t255: got %h %h expected 8000 0000",
               got[15], got[14]);
      errors++;
    end
    checks++;
    if (got[1023] !== 16'h8000) begin
      $display("FAIL b2b_last: got %h expected 8000", got[1023]);
      errors++;
    end
    checks++;
    if (obj_count !== 15'd64) begin
      $display("FAIL b2b_count: got %0d expected 64", obj_count);
      errors++;
    end
  endtask

  task automatic test_thr0_disturb;
    int cyc;
    int bad;
    for (int a = 0; a < 16384; a++) mem[a] = 8'(a * 37 + 11);
    run_pass(8'd0, 1'b1, cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_rd !== 1'b0) begin
      $display("FAIL done_start: got busy=%b rd=%b expected 0 0",
               busy, res_rd);
      errors++;
    end
    checks++;
    if (cyc !== 17409 || wr_cnt != 1024) begin
      $display("FAIL thr0_timing: got %0d cyc %0d wr expected 17409 1024",
               cyc, wr_cnt);
      errors++;
    end
    bad = 0;
    for (int w = 0; w < 1024; w++) if (got[w] !== 16'hFFFF) bad++;
    checks++;
    if (bad != 0) begin
      $display("FAIL thr0_words: got %0d bad words expected 0", bad);
      errors++;
    end
    checks++;
    if (obj_count !== 15'd16384) begin
      $display("FAIL thr0_count: got %0d expected 16384", obj_count);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    int  cyc;
    int  bad;
    bit  hit;
    for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
    mem[16 * 5 + 3] = 8'd9;
    @(negedge clk);
    start = 1'b1;
    threshold = 8'd9;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (res_rd && res_addr == 14'(300 * 16 + 5)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      $display("FAIL mid_reach: got no word 300 read expected one");
      errors++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({res_rd, sti_wr, busy, done, res_addr} !== 18'd0) begin
      $display("FAIL mid_outputs: got %h expected 0",
               {res_rd, sti_wr, busy, done, res_addr});
      errors++;
    end
    checks++;
    if (obj_count !== 15'd0) begin
      $display("FAIL mid_count: got %0d expected 0", obj_count);
      errors++;
    end
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 3) reset = 1'b1;
      if (sti_wr || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL mid_quiet: got %0d active cycles expected 0", bad);
      errors++;
    end
    run_pass(8'd9, 1'b0, cyc);
    checks++;
    if (cyc !== 17409 || wr_cnt != 1024 || order_bad != 0) begin
      $display("FAIL single_pass: got cyc=%0d wr=%0d ord=%0d expected 17409 1024 0",
               cyc, wr_cnt, order_bad);
      errors++;
    end
    checks++;
    if (got[5] !== 16'h0008) begin
      $display("FAIL single_word5: got %h expected 0008", got[5]);
      errors++;
    end
    bad = 0;
    for (int w = 0; w < 1024; w++)
      if (w != 5 && got[w] !== 16'h0000) bad++;
    checks++;
    if (bad != 0) begin
      $display("FAIL single_others: got %0d nonzero expected 0", bad);
      errors++;
    end
    checks++;
    if (obj_count !== 15'd1) begin
      $display("FAIL single_count: got %0d expected 1", obj_count);
      errors++;
    end
    checks++;
    if (rd_bad != 0 || idle_bad != 0) begin
      $display("FAIL single_strobes: got rd=%0d idle=%0d expected 0 0",
               rd_bad, idle_bad);
      errors++;
    end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
    test_reset;
    test_ramp;
    test_back_to_back;
    test_thr0_disturb;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
